// File: rtl/z80_bus_target.sv
// z80_bus_target
// Responder end of the Z80 core bus. Decodes memory, IO and interrupt-acknowledge
// cycles, serves an on-chip RAM and a four-register IO block that holds a periodic
// timer, stretches cycles with WAIT and raises INT while the timer interrupt is pending.
//
// Ports
//   CLK   in   rising-edge clock for all logic
//   RESET in   synchronous active-high reset
//   ADDR  in   16-bit address from the core
//   DO    in   8-bit write data from the core
//   WR    in   write strobe
//   MREQ  in   memory request
//   IORQ  in   IO request
//   M1    in   opcode fetch / interrupt-acknowledge qualifier
//   DI    out  8-bit read data to the core (8'hFF when idle or unmapped)
//   WAIT  out  wait request, high while the cycle is being stretched
//   INT   out  maskable interrupt level
module z80_bus_target #(
    parameter int          RAM_AW     = 10,
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter logic [7:0]  IO_BASE    = 8'h10,
    parameter int          MEM_WAIT   = 1,
    parameter int          IO_WAIT    = 2,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DO,
    input  logic        WR,
    input  logic        MREQ,
    input  logic        IORQ,
    input  logic        M1,
    output logic [7:0]  DI,
    output logic        WAIT,
    output logic        INT
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAITS = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {CY_MEM = 2'd0, CY_IO = 2'd1, CY_INTACK = 2'd2} cyc_t;

    localparam logic [3:0] MEM_N = 4'(MEM_WAIT);
    localparam logic [3:0] IO_N  = 4'(IO_WAIT);

    state_t      state_r, state_nx_s;
    cyc_t        cyc_r, cyc_in_s, cyc_s;
    logic [3:0]  cnt_r, cnt_nx_s, n_s;
    logic        strobe_s, strobe_prev_r, start_s, done_entry_s;
    logic        ram_hit_s, io_hit_s, mem_we_s, io_we_s;
    logic [7:0]  rdata_s, di_r;
    logic        wait_r, int_r;
    logic [7:0]  ram_r [0:(1<<RAM_AW)-1];
    logic [7:0]  reload_r, scratch_r, count_r;
    logic        ten_r, ie_r, pend_r;
    logic        ten_rise_s, expire_s, pend_clr_s;

    assign strobe_s  = MREQ | IORQ;
    assign start_s   = (state_r == ST_IDLE) && strobe_s && !strobe_prev_r;
    assign ram_hit_s = (ADDR[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign io_hit_s  = (ADDR[7:2] == IO_BASE[7:2]);

    // Cycle type decode; the type is frozen at start so later strobe changes cannot retype it
    always_comb begin
        cyc_in_s = CY_IO;
        if (M1 && IORQ) begin
            cyc_in_s = CY_INTACK;
        end else if (MREQ) begin
            cyc_in_s = CY_MEM;
        end else begin
            cyc_in_s = CY_IO;
        end
        cyc_s = (state_r == ST_IDLE) ? cyc_in_s : cyc_r;
        n_s   = (cyc_s == CY_MEM) ? MEM_N : IO_N;
    end

    // Next-state logic: strobe loss during WAITS aborts ahead of completion
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (n_s != 4'd0) begin
                        state_nx_s = ST_WAITS;
                        cnt_nx_s   = n_s - 4'd1;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAITS: begin
                if (!strobe_s) begin
                    state_nx_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                if (!strobe_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign done_entry_s = (state_nx_s == ST_DONE) && (state_r != ST_DONE);
    assign mem_we_s     = done_entry_s && (cyc_s == CY_MEM) && WR && ram_hit_s;
    assign io_we_s      = done_entry_s && (cyc_s == CY_IO) && WR && io_hit_s;

    // Read-data mux evaluated at DONE entry
    always_comb begin
        rdata_s = 8'hFF;
        case (cyc_s)
            CY_INTACK: rdata_s = INT_VECTOR;
            CY_MEM: begin
                if (ram_hit_s) begin
                    rdata_s = ram_r[ADDR[RAM_AW-1:0]];
                end else begin
                    rdata_s = 8'hFF;
                end
            end
            CY_IO: begin
                if (io_hit_s) begin
                    case (ADDR[1:0])
                        2'd0:    rdata_s = reload_r;
                        2'd1:    rdata_s = {6'd0, ie_r, ten_r};
                        2'd2:    rdata_s = {7'd0, pend_r};
                        2'd3:    rdata_s = scratch_r;
                        default: rdata_s = 8'hFF;
                    endcase
                end else begin
                    rdata_s = 8'hFF;
                end
            end
            default: rdata_s = 8'hFF;
        endcase
    end

    // FSM state, wait counter, latched cycle type and strobe history
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 4'd0;
            cyc_r         <= CY_MEM;
            strobe_prev_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            strobe_prev_r <= strobe_s;
            if (start_s) begin
                cyc_r <= cyc_in_s;
            end
        end
    end

    // Registered bus outputs: DI captured at DONE entry and parked at 8'hFF otherwise
    always_ff @(posedge CLK) begin
        if (RESET) begin
            di_r   <= 8'hFF;
            wait_r <= 1'b0;
        end else begin
            wait_r <= (state_nx_s == ST_WAITS);
            if (done_entry_s) begin
                di_r <= rdata_s;
            end else if (state_nx_s != ST_DONE) begin
                di_r <= 8'hFF;
            end
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (mem_we_s && !RESET) begin
            ram_r[ADDR[RAM_AW-1:0]] <= DO;
        end
    end

    assign ten_rise_s = io_we_s && (ADDR[1:0] == 2'd1) && DO[0] && !ten_r;
    assign expire_s   = ten_r && (count_r == 8'd0);
    assign pend_clr_s = (io_we_s && (ADDR[1:0] == 2'd2) && DO[0]) ||
                        (done_entry_s && (cyc_s == CY_INTACK));

    // IO registers and timer; expiry beats a same-cycle clear so no interrupt is lost
    always_ff @(posedge CLK) begin
        if (RESET) begin
            reload_r  <= 8'd0;
            scratch_r <= 8'd0;
            ten_r     <= 1'b0;
            ie_r      <= 1'b0;
            pend_r    <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            if (io_we_s) begin
                case (ADDR[1:0])
                    2'd0:    reload_r <= DO;
                    2'd1:    begin ten_r <= DO[0]; ie_r <= DO[1]; end
                    2'd3:    scratch_r <= DO;
                    default: ;
                endcase
            end
            if (ten_rise_s) begin
                count_r <= reload_r;
            end else if (expire_s) begin
                count_r <= reload_r;
            end else if (ten_r) begin
                count_r <= count_r - 8'd1;
            end
            if (expire_s) begin
                pend_r <= 1'b1;
            end else if (pend_clr_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Interrupt output lags PEND/IE by one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            int_r <= 1'b0;
        end else begin
            int_r <= pend_r && ie_r;
        end
    end

    assign DI   = di_r;
    assign WAIT = wait_r;
    assign INT  = int_r;

endmodule
